// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default bus widths and data-memory FSM encoding.
// No logic, no latency.
// No flow control; types and constants only.
package cpu_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dmem_responder_lat_counter.sv
// Loadable down-counter with a zero flag, used to time the BUSY phase of an access.
// Load and decrement take effect on the next clock edge; zero is combinational from the count.
// No handshake; decrement requests at zero are ignored so the count saturates at 0.
module dmem_responder_lat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  assign zero = (count == '0);

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed read/write latency, one-cycle response.
// Response is sampled by the edge at acceptance+LAT; next acceptance possible at acceptance+LAT+1.
// req_ready is low from acceptance through the response cycle; no response backpressure.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 256,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall
);

  localparam int MAX_LAT = max_int(READ_LAT, WRITE_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The counter holds the BUSY cycles still to run after the current one, so a latency
  // of LAT spends LAT-1 cycles in BUSY and LAT==1 skips BUSY entirely.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((READ_LAT  >= 2) ? READ_LAT  - 2 : 0);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WRITE_LAT >= 2) ? WRITE_LAT - 2 : 0);

  dmem_state_t           state;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_write;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  req_lat1;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_load_val;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_write;
  logic                  acc_in_range;
  logic [DATA_WIDTH-1:0] rd_val;

  assign stall = req_valid & ~rsp_valid;

  // Access decode: a single-cycle access commits on its own acceptance edge, so the
  // commit path takes the live request in IDLE and the captured request in BUSY.
  always_comb begin
    accept       = (state == ST_IDLE) && req_valid;
    req_lat1     = req_write ? (WRITE_LAT == 1) : (READ_LAT == 1);
    cnt_load     = accept && !req_lat1;
    cnt_load_val = req_write ? WR_LOAD : RD_LOAD;
    cnt_dec      = (state == ST_BUSY) && !cnt_zero;
    commit       = (accept && req_lat1) || ((state == ST_BUSY) && cnt_zero);
    acc_addr     = (state == ST_IDLE) ? req_addr  : cap_addr;
    acc_wdata    = (state == ST_IDLE) ? req_wdata : cap_wdata;
    acc_write    = (state == ST_IDLE) ? req_write : cap_write;
    // Full address compared, so out-of-range addresses never alias onto real words.
    acc_in_range = (32'(acc_addr) < 32'(DEPTH));
    rd_val       = '0;
    if (!acc_write && acc_in_range) begin
      rd_val = mem[acc_addr[IDX_W-1:0]];
    end
  end

  dmem_responder_lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Storage update only on the commit edge; gated by reset so an aborted store is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && commit && acc_write && acc_in_range) begin
      mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
    end
  end

  // Access FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_write <= req_write;
            req_ready <= 1'b0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          req_ready <= 1'b0;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
      if (commit) begin
        state     <= ST_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= ~acc_in_range;
        rsp_rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with different depth/latency settings.
// A transaction-level model predicts every output on every cycle; directed requests pin values.
// Stimulus drives just after each rising edge, outputs are sampled on the falling edge.
module tb_dmem_responder;

  localparam int N = 4;

  function automatic int depth_of(input int i);
    return (i == 0) ? 200 : 256;
  endfunction
  function automatic int rl_of(input int i);
    case (i)
      2:       return 1;
      3:       return 4;
      default: return 2;
    endcase
  endfunction
  function automatic int wl_of(input int i);
    case (i)
      1:       return 3;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [N];
  logic        req_valid [N];
  logic        req_write [N];
  logic [7:0]  req_addr  [N];
  logic [15:0] req_wdata [N];
  logic        req_ready [N];
  logic        rsp_valid [N];
  logic [15:0] rsp_rdata [N];
  logic        rsp_err   [N];
  logic        stall     [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (16),
        .DEPTH      (depth_of(g)),
        .READ_LAT   (rl_of(g)),
        .WRITE_LAT  (wl_of(g))
      ) u_dut (
        .clk       (clk),
        .reset_n   (rst_n[g]),
        .req_valid (req_valid[g]),
        .req_write (req_write[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .req_ready (req_ready[g]),
        .rsp_valid (rsp_valid[g]),
        .rsp_rdata (rsp_rdata[g]),
        .rsp_err   (rsp_err[g]),
        .stall     (stall[g])
      );
    end
  endgenerate

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Transaction-level model state per instance
  bit          m_pend   [N];
  bit          m_vld    [N];
  logic [15:0] m_rdata  [N];
  bit          m_err    [N];
  bit          m_dknown [N];
  int          m_due    [N];
  bit          m_wr     [N];
  logic [7:0]  m_addr   [N];
  logic [15:0] m_wdata  [N];
  logic [15:0] m_mem    [N][256];
  bit          m_known  [N][256];

  // Values sampled on the most recent falling edge
  logic        s_rdy   [N];
  logic        s_vld   [N];
  logic [15:0] s_rdata [N];
  logic        s_err   [N];
  logic        s_stall [N];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h", nm, idx, cyc, act, exp_v);
    end
  endtask

  task automatic respond(input int i);
    m_vld[i] = 1'b1;
    if (int'(m_addr[i]) < depth_of(i)) begin
      m_err[i] = 1'b0;
      if (m_wr[i]) begin
        m_mem[i][m_addr[i]]   = m_wdata[i];
        m_known[i][m_addr[i]] = 1'b1;
        m_rdata[i]  = 16'h0;
        m_dknown[i] = 1'b1;
      end else begin
        m_rdata[i]  = m_mem[i][m_addr[i]];
        m_dknown[i] = m_known[i][m_addr[i]];
      end
    end else begin
      m_err[i]    = 1'b1;
      m_rdata[i]  = 16'h0;
      m_dknown[i] = 1'b1;
    end
  endtask

  // Model step at a rising edge: acceptance when free, response at acceptance+LAT-1 edge
  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      if (!rst_n[i]) begin
        m_pend[i] = 1'b0; m_vld[i] = 1'b0; m_rdata[i] = 16'h0; m_err[i] = 1'b0; m_dknown[i] = 1'b1;
      end else if (m_vld[i]) begin
        m_pend[i] = 1'b0; m_vld[i] = 1'b0; m_rdata[i] = 16'h0; m_err[i] = 1'b0; m_dknown[i] = 1'b1;
      end else if (m_pend[i]) begin
        if (cyc == m_due[i]) respond(i);
      end else if (req_valid[i]) begin
        int lat;
        lat       = req_write[i] ? wl_of(i) : rl_of(i);
        m_pend[i] = 1'b1;
        m_wr[i]   = req_write[i];
        m_addr[i] = req_addr[i];
        m_wdata[i] = req_wdata[i];
        m_due[i]  = cyc + lat - 1;
        if (lat == 1) respond(i);
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      logic er, ev, ee;
      logic [15:0] ed;
      bit dk;
      if (!rst_n[i]) begin
        er = 1'b1; ev = 1'b0; ee = 1'b0; ed = 16'h0; dk = 1'b1;
      end else begin
        er = !m_pend[i]; ev = m_vld[i]; ee = m_err[i]; ed = m_rdata[i]; dk = m_dknown[i];
      end
      check("req_ready", i, 32'(req_ready[i]), 32'(er));
      check("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
      check("rsp_err",   i, 32'(rsp_err[i]),   32'(ee));
      check("stall",     i, 32'(stall[i]),     32'(req_valid[i] & ~ev));
      if (dk) check("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(ed));
      s_rdy[i]   = req_ready[i];
      s_vld[i]   = rsp_valid[i];
      s_rdata[i] = rsp_rdata[i];
      s_err[i]   = rsp_err[i];
      s_stall[i] = stall[i];
    end
  endtask

  // One cycle: compare on the falling edge, advance the model on the rising edge, then drive
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Present a request on an idle responder and wait for its response pulse
  task automatic do_req(input int i, input bit wr, input logic [7:0] addr, input logic [15:0] wdata,
                        input bit hold, input int exp_lat, input logic [15:0] exp_rdata,
                        input bit exp_err, input string nm, output int acc);
    int k;
    bit got;
    k   = 0;
    got = 1'b0;
    acc = cyc;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    for (int t = 0; t < 40; t++) begin
      step();
      if (s_vld[i]) begin
        got = 1'b1;
        break;
      end
      k++;
    end
    check({nm, "_got_rsp"}, i, 32'(got), 32'd1);
    check({nm, "_latency"}, i, 32'(k), 32'(exp_lat));
    check({nm, "_rdata"},   i, 32'(s_rdata[i]), 32'(exp_rdata));
    check({nm, "_err"},     i, 32'(s_err[i]), 32'(exp_err));
    if (!hold) req_valid[i] = 1'b0;
  endtask

  initial begin
    int a0, a1, a2;
    int nv;
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = 8'h0; req_wdata[i] = 16'h0;
      m_pend[i] = 1'b0; m_vld[i] = 1'b0; m_rdata[i] = 16'h0; m_err[i] = 1'b0; m_dknown[i] = 1'b1;
      m_due[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 8'h0; m_wdata[i] = 16'h0;
      for (int j = 0; j < 256; j++) begin
        m_mem[i][j] = 16'h0;
        m_known[i][j] = 1'b0;
      end
    end

    // Reset state, stall following req_valid while held in reset
    step();
    step();
    req_valid[0] = 1'b1;
    step();
    check("rst_req_ready", 0, 32'(s_rdy[0]),   32'd1);
    check("rst_rsp_valid", 0, 32'(s_vld[0]),   32'd0);
    check("rst_rsp_rdata", 0, 32'(s_rdata[0]), 32'd0);
    check("rst_rsp_err",   0, 32'(s_err[0]),   32'd0);
    check("rst_stall",     0, 32'(s_stall[0]), 32'd1);
    req_valid[0] = 1'b0;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    step();

    // Store then load at the same address, second acceptance two cycles after the first
    do_req(0, 1'b1, 8'h10, 16'hBEEF, 1'b1, 1, 16'h0000, 1'b0, "st10", a0);
    do_req(0, 1'b0, 8'h10, 16'h0000, 1'b0, 2, 16'hBEEF, 1'b0, "ld10", a1);
    check("st_ld_spacing", 0, 32'(a1 - a0), 32'd2);
    step();

    // Out of range with DEPTH=200: no aliasing of 0xC8 onto 0x48, edge at 199
    do_req(0, 1'b1, 8'h48, 16'h7777, 1'b0, 1, 16'h0000, 1'b0, "st48", a0);
    do_req(0, 1'b0, 8'hC8, 16'h0000, 1'b0, 2, 16'h0000, 1'b1, "ldC8", a0);
    do_req(0, 1'b1, 8'hC8, 16'h1234, 1'b0, 1, 16'h0000, 1'b1, "stC8", a0);
    do_req(0, 1'b0, 8'h48, 16'h0000, 1'b0, 2, 16'h7777, 1'b0, "ld48", a0);
    do_req(0, 1'b1, 8'hC7, 16'h0C7C, 1'b0, 1, 16'h0000, 1'b0, "stC7", a0);
    do_req(0, 1'b0, 8'hC7, 16'h0000, 1'b0, 2, 16'h0C7C, 1'b0, "ldC7", a0);
    do_req(0, 1'b0, 8'hFF, 16'h0000, 1'b0, 2, 16'h0000, 1'b1, "ldFF", a0);

    // Back-to-back loads with req_valid held throughout
    do_req(0, 1'b1, 8'h01, 16'h1111, 1'b0, 1, 16'h0000, 1'b0, "st01", a0);
    do_req(0, 1'b1, 8'h02, 16'h2222, 1'b0, 1, 16'h0000, 1'b0, "st02", a0);
    do_req(0, 1'b1, 8'h03, 16'h3333, 1'b0, 1, 16'h0000, 1'b0, "st03", a0);
    step();
    do_req(0, 1'b0, 8'h01, 16'h0000, 1'b1, 2, 16'h1111, 1'b0, "b2b_ld01", a0);
    do_req(0, 1'b0, 8'h02, 16'h0000, 1'b1, 2, 16'h2222, 1'b0, "b2b_ld02", a1);
    do_req(0, 1'b0, 8'h03, 16'h0000, 1'b0, 2, 16'h3333, 1'b0, "b2b_ld03", a2);
    check("b2b_spacing_1", 0, 32'(a1 - a0), 32'd3);
    check("b2b_spacing_2", 0, 32'(a2 - a1), 32'd3);
    step();

    // Reset one cycle after accepting a 3-cycle store: no response, storage untouched
    do_req(1, 1'b1, 8'h20, 16'hAAAA, 1'b0, 3, 16'h0000, 1'b0, "st20", a0);
    step();
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 8'h20;
    req_wdata[1] = 16'h5555;
    step();
    step();
    rst_n[1]     = 1'b0;
    req_valid[1] = 1'b0;
    nv = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      nv += int'(s_vld[1]);
    end
    check("abort_no_rsp", 1, 32'(nv), 32'd0);
    rst_n[1] = 1'b1;
    step();
    do_req(1, 1'b0, 8'h20, 16'h0000, 1'b0, 2, 16'hAAAA, 1'b0, "ld20_after_abort", a0);

    // Latency sweep: READ_LAT=1/WRITE_LAT=4 and READ_LAT=4/WRITE_LAT=1
    do_req(2, 1'b1, 8'h30, 16'h4C4C, 1'b0, 4, 16'h0000, 1'b0, "sw_st30", a0);
    do_req(2, 1'b0, 8'h30, 16'h0000, 1'b1, 1, 16'h4C4C, 1'b0, "sw_ld30a", a0);
    do_req(2, 1'b0, 8'h30, 16'h0000, 1'b0, 1, 16'h4C4C, 1'b0, "sw_ld30b", a1);
    check("sw_rl1_spacing", 2, 32'(a1 - a0), 32'd2);
    do_req(3, 1'b1, 8'h31, 16'h3D3D, 1'b0, 1, 16'h0000, 1'b0, "sw_st31", a0);
    do_req(3, 1'b0, 8'h31, 16'h0000, 1'b0, 4, 16'h3D3D, 1'b0, "sw_ld31", a0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
